// File: rtl/shift_exec_stage_if.sv
// ---------------------------------------------------------------------------
// shift_exec_stage_if : upstream/downstream handshake and data bundle for
//                       shift_exec_stage.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface shift_exec_stage_if #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 5
);
  logic                  in_flush;
  logic                  in_valid;
  logic                  out_ready;
  logic [2:0]            in_op;
  logic [DATA_WIDTH-1:0] in_numA;
  logic [DATA_WIDTH-1:0] in_numB;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  in_downReady;
  logic [DATA_WIDTH-1:0] out_result;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic                  out_err;

  modport master (
    output in_flush, in_valid, in_op, in_numA, in_numB, in_tag, in_downReady,
    input  out_ready, out_valid, out_result, out_tag, out_err
  );

  modport slave (
    input  in_flush, in_valid, in_op, in_numA, in_numB, in_tag, in_downReady,
    output out_ready, out_valid, out_result, out_tag, out_err
  );
endinterface

`default_nettype wire

// File: rtl/shift_exec_stage.sv
// ---------------------------------------------------------------------------
// shift_exec_stage : 64-bit shift execute stage with a 2-entry result FIFO.
// Optional macro SHIFT_EXEC_WORD_EN enables the 32-bit W shift opcodes.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module shift_exec_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 5
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  shift_exec_stage_if.slave bus
);

  localparam logic [2:0] c_OP_SLL  = 3'b000;
  localparam logic [2:0] c_OP_SRL  = 3'b001;
  localparam logic [2:0] c_OP_SRA  = 3'b010;
`ifdef SHIFT_EXEC_WORD_EN
  localparam logic [2:0] c_OP_SLLW = 3'b100;
  localparam logic [2:0] c_OP_SRLW = 3'b101;
  localparam logic [2:0] c_OP_SRAW = 3'b110;
`endif
  localparam logic [1:0] c_FULL    = 2'd2;

  // ---------------------------------------------------------------- datapath
  logic [5:0]                   w_amt;
  logic signed [DATA_WIDTH-1:0] w_sra_s;
  logic [DATA_WIDTH-1:0]        w_res;
  logic                         w_err;
  logic                         unused_numb;

  assign w_amt       = bus.in_numB[5:0];
  assign w_sra_s     = $signed(bus.in_numA) >>> w_amt;
  assign unused_numb = ^bus.in_numB[DATA_WIDTH-1:6];

`ifdef SHIFT_EXEC_WORD_EN
  logic [4:0]         w_amt_w;
  logic [31:0]        w_sllw;
  logic [31:0]        w_srlw;
  logic signed [31:0] w_sraw_s;

  assign w_amt_w  = bus.in_numB[4:0];
  assign w_sllw   = bus.in_numA[31:0] << w_amt_w;
  assign w_srlw   = bus.in_numA[31:0] >> w_amt_w;
  assign w_sraw_s = $signed(bus.in_numA[31:0]) >>> w_amt_w;
`endif

  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    case (bus.in_op)
      c_OP_SLL:  w_res = bus.in_numA << w_amt;
      c_OP_SRL:  w_res = bus.in_numA >> w_amt;
      c_OP_SRA:  w_res = w_sra_s;
`ifdef SHIFT_EXEC_WORD_EN
      c_OP_SLLW: w_res = {{(DATA_WIDTH-32){w_sllw[31]}}, w_sllw};
      c_OP_SRLW: w_res = {{(DATA_WIDTH-32){w_srlw[31]}}, w_srlw};
      c_OP_SRAW: w_res = {{(DATA_WIDTH-32){w_sraw_s[31]}}, w_sraw_s};
`endif
      default:   w_err = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- FIFO
  logic [1:0]            count_q, count_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] res_q [2];
  logic [TAG_WIDTH-1:0]  tag_q [2];
  logic [1:0]            err_q;

  logic w_ready;
  logic w_valid;
  logic w_push;
  logic w_pop;

  // Ready comes from the count register alone, so downstream stalls never
  // ripple combinationally back to the upstream stage.
  assign w_ready = (count_q != c_FULL);
  assign w_valid = (count_q != 2'd0);
  assign w_push  = bus.in_valid && w_ready;
  assign w_pop   = w_valid && bus.in_downReady;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.in_flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (w_push) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        res_q[i] <= '0;
        tag_q[i] <= '0;
      end
      err_q <= '0;
    end else if (w_push && !bus.in_flush) begin
      res_q[wr_ptr_q] <= w_res;
      tag_q[wr_ptr_q] <= bus.in_tag;
      err_q[wr_ptr_q] <= w_err;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus.out_ready  = w_ready;
  assign bus.out_valid  = w_valid;
  assign bus.out_result = w_valid ? res_q[rd_ptr_q] : '0;
  assign bus.out_tag    = w_valid ? tag_q[rd_ptr_q] : '0;
  assign bus.out_err    = w_valid ? err_q[rd_ptr_q] : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_shift_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_shift_exec_stage : directed and random checks of shift_exec_stage
// against a queue-based reference model.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_shift_exec_stage;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t mq[$];

  shift_exec_stage_if #(.DATA_WIDTH(64), .TAG_WIDTH(5)) bus ();

  shift_exec_stage #(.DATA_WIDTH(64), .TAG_WIDTH(5)) u_dut (
    .in_clk   (clk),
    .in_rst_n (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t ref_op(input logic [2:0] op, input logic [63:0] a,
                                  input logic [63:0] b, input logic [4:0] tag);
    exp_t        e;
    int          sh;
    logic [31:0] a32;
    logic [31:0] r32;
    e.tag = tag;
    e.err = 1'b0;
    e.res = 64'd0;
    sh    = int'(b[5:0]);
    a32   = a[31:0];
    r32   = 32'd0;
    case (op)
      3'd0: e.res = a << sh;
      3'd1: e.res = a >> sh;
      3'd2: e.res = a[63] ? ~((~a) >> sh) : (a >> sh);
`ifdef SHIFT_EXEC_WORD_EN
      3'd4, 3'd5, 3'd6: begin
        sh = int'(b[4:0]);
        if (op == 3'd4)      r32 = a32 << sh;
        else if (op == 3'd5) r32 = a32 >> sh;
        else                 r32 = a32[31] ? ~((~a32) >> sh) : (a32 >> sh);
        e.res = {{32{r32[31]}}, r32};
      end
`endif
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "_valid"}, 64'(bus.out_valid), 64'(mq.size() != 0));
    chk({pfx, "_ready"}, 64'(bus.out_ready), 64'(mq.size() != 2));
    if (mq.size() != 0) begin
      chk({pfx, "_result"}, bus.out_result, mq[0].res);
      chk({pfx, "_tag"},    64'(bus.out_tag), 64'(mq[0].tag));
      chk({pfx, "_err"},    64'(bus.out_err), 64'(mq[0].err));
    end else begin
      chk({pfx, "_result0"}, bus.out_result, 64'd0);
      chk({pfx, "_tag0"},    64'(bus.out_tag), 64'd0);
      chk({pfx, "_err0"},    64'(bus.out_err), 64'd0);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] tag);
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_numA  = a;
    bus.in_numB  = b;
    bus.in_tag   = tag;
  endtask

  // One clock: predict from pre-edge inputs, advance, compare.
  task automatic cycle(input string pfx);
    logic push;
    logic pop;
    exp_t e;
    push = bus.in_valid && (mq.size() != 2);
    pop  = (mq.size() != 0) && bus.in_downReady;
    e    = ref_op(bus.in_op, bus.in_numA, bus.in_numB, bus.in_tag);
    @(posedge clk);
    #1;
    if (bus.in_flush) begin
      mq.delete();
    end else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(e);
    end
    check_outputs(pfx);
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst_n            = 1'b0;
    bus.in_flush     = 1'b0;
    bus.in_downReady = 1'b0;
    drive(1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // SRA with full-width sign fill
    bus.in_downReady = 1'b1;
    drive(1'b1, 3'b010, 64'h8000_0000_0000_0000, 64'h3F, 5'd7);
    cycle("sra");
    chk("sra_const", bus.out_result, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sra_err", 64'(bus.out_err), 64'd0);
    drive(1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
    cycle("sra_drain");

    drive(1'b1, 3'b011, 64'h1234, 64'h1, 5'd9);
    cycle("ill011");
    chk("ill011_res", bus.out_result, 64'd0);
    chk("ill011_err", 64'(bus.out_err), 64'd1);

`ifdef SHIFT_EXEC_WORD_EN
    drive(1'b1, 3'b101, 64'hFFFF_FFFF_8000_0000, 64'h21, 5'd10);
    cycle("srlw");
    chk("srlw_const", bus.out_result, 64'h0000_0000_4000_0000);
    drive(1'b1, 3'b100, 64'h1, 64'd31, 5'd11);
    cycle("sllw");
    chk("sllw_const", bus.out_result, 64'hFFFF_FFFF_8000_0000);
`else
    drive(1'b1, 3'b110, 64'hFFFF_0000_1234_5678, 64'h4, 5'd12);
    cycle("ill110");
    chk("ill110_res", bus.out_result, 64'd0);
    chk("ill110_err", 64'(bus.out_err), 64'd1);
`endif
    drive(1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
    cycle("drain1");

    // Backpressure: three ops, only two fit
    bus.in_downReady = 1'b0;
    drive(1'b1, 3'd0, 64'h1, 64'd1, 5'd1);
    cycle("bp1");
    drive(1'b1, 3'd1, 64'hF0, 64'd4, 5'd2);
    cycle("bp2");
    chk("bp_full", 64'(bus.out_ready), 64'd0);
    drive(1'b1, 3'd2, 64'hFFFF_0000_0000_0000, 64'd8, 5'd3);
    cycle("bp3");
    chk("bp_hold_tag", 64'(bus.out_tag), 64'd1);
    bus.in_downReady = 1'b1;
    cycle("bp_rel1");
    chk("bp_tag2", 64'(bus.out_tag), 64'd2);
    cycle("bp_rel2");
    chk("bp_tag3", 64'(bus.out_tag), 64'd3);
    drive(1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
    cycle("bp_rel3");

    // Simultaneous push/pop at count 1
    drive(1'b1, 3'd0, 64'h3, 64'd2, 5'd20);
    cycle("pp_a");
    drive(1'b1, 3'd1, 64'h300, 64'd4, 5'd21);
    cycle("pp_b");
    chk("pp_newhead", 64'(bus.out_tag), 64'd21);
    drive(1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
    cycle("pp_drain");

    // Flush with a pending push at count 2
    bus.in_downReady = 1'b0;
    drive(1'b1, 3'd0, 64'h5, 64'd1, 5'd4);
    cycle("fl1");
    drive(1'b1, 3'd0, 64'h6, 64'd1, 5'd5);
    cycle("fl2");
    drive(1'b1, 3'd0, 64'h7, 64'd1, 5'd6);
    bus.in_flush = 1'b1;
    cycle("flush");
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    bus.in_flush = 1'b0;
    drive(1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
    cycle("post_flush");

    // Asynchronous reset while full
    drive(1'b1, 3'd0, 64'h8, 64'd1, 5'd8);
    cycle("ar1");
    drive(1'b1, 3'd0, 64'h9, 64'd1, 5'd9);
    cycle("ar2");
    drive(1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, 3'($urandom_range(0, 7)),
            {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
      bus.in_downReady = ($urandom % 3) != 0;
      bus.in_flush     = ($urandom % 25) == 0;
      cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
